voice_mix_sequencer: RTL and testbench
======================================

VOICE_MIX_SEQUENCER -- requirements
Module: voice_mix_sequencer

Interface
REQ-001 Parameter DEFAULT_GAIN, 8'd128: per-voice gain after reset, unsigned Q1.7 (128 = unity).
REQ-002 Parameter SAT_OVR, 1'b1: overrun counter saturates at 255 when 1, wraps to 0 when 0.
REQ-003 clk  in  1  system clock (100 MHz); all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 in_ready  in  1  one-cycle pulse; wave0_in..wave2_in valid this cycle.
REQ-006 wave0_in, wave1_in, wave2_in  in  16 each  signed voice samples.
REQ-007 mute  in  3  bit i forces voice i contribution to 0; sampled at capture.
REQ-008 gain_wr  in  1  gain register write strobe.
REQ-009 gain_sel  in  2  target voice 0..2; value 3 is ignored.
REQ-010 gain_data  in  8  unsigned Q1.7 gain value.
REQ-011 out  out  16  signed mixed sample, registered.
REQ-012 out_ready  out  1  one-cycle pulse; out valid in the same cycle.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 overrun_count  out  8  count of dropped in_ready pulses.

Function
REQ-015 The block SHALL use one shared 16x9 signed multiplier, one product per cycle, sequenced by FSM states IDLE, MAC0, MAC1, MAC2, OUT.
REQ-016 IDLE with in_ready=1 SHALL capture the three samples, the mute bits, and a snapshot of the three gains, clear the 26-bit accumulator, and go to MAC0.
REQ-017 MACi SHALL add sample_i * {1'b0, gain_i} (24-bit signed product, sign-extended) to the accumulator, or add 0 if mute_i; MAC0->MAC1->MAC2->OUT unconditionally.
REQ-018 OUT SHALL register out = sat16(acc >>> 7), using an arithmetic shift that floors, pulse out_ready for exactly one cycle, and return to IDLE.
REQ-019 sat16 SHALL clamp to +32767 / -32768; in-range values SHALL pass unchanged.
REQ-020 Latency: in_ready sampled at edge k SHALL give out_ready high in the cycle following edge k+5.
REQ-021 out SHALL hold its value between out_ready pulses.
REQ-022 in_ready in any non-IDLE state, including OUT, SHALL be dropped and SHALL increment overrun_count, saturating or wrapping per SAT_OVR.
REQ-023 gain_wr SHALL update gain[gain_sel] on the next edge in any state; the current sample SHALL use only its snapshot.
REQ-024 gain_wr and in_ready in the same IDLE cycle SHALL write the register and snapshot the pre-write gain.
REQ-025 gain_sel=3 with gain_wr SHALL change no state.

Reset
REQ-026 reset SHALL force state IDLE, out=0, out_ready=0, busy=0, overrun_count=0, accumulator=0, and all gains=DEFAULT_GAIN; reset has priority over all inputs.
REQ-027 reset mid-operation SHALL abort the sample, with no out_ready pulse before or after reset.

Verification
REQ-028 Defaults; wave=1000,2000,-500, in_ready pulse -> out=2500, out_ready exactly 5 cycles later, busy high 5 cycles.
REQ-029 Defaults; 30000,30000,0 -> out=32767; -30000,-30000,-30000 -> out=-32768.
REQ-030 gain0=64, gain1=gain2=0; wave0=1001 -> out=500; wave0=-1001 -> out=-501 (floor).
REQ-031 in_ready, then in_ready again 2 cycles later -> one out_ready only, overrun_count=1; with SAT_OVR=1, 300 dropped pulses -> overrun_count=255.
REQ-032 gain_wr sel=1 data=0 during MAC0 for samples 100,100,100 -> out=300; next sample 100,100,100 -> out=200; mute=3'b100 on the following sample -> out=100.
REQ-033 reset asserted in MAC1 -> out=0, busy=0, no out_ready; next in_ready of 7,7,7 -> out=21.

Source files
------------

// File: rtl/voice_mix_sequencer.sv
// voice_mix_sequencer: three-voice gain/mute mixer sharing one 16x9 multiplier, saturated 16-bit output
module voice_mix_sequencer #(
  parameter logic [7:0] DEFAULT_GAIN = 8'd128,
  parameter logic       SAT_OVR      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_ready,
  input  logic [15:0] wave0_in,
  input  logic [15:0] wave1_in,
  input  logic [15:0] wave2_in,
  input  logic [2:0]  mute,
  input  logic        gain_wr,
  input  logic [1:0]  gain_sel,
  input  logic [7:0]  gain_data,
  output logic [15:0] out,
  output logic        out_ready,
  output logic        busy,
  output logic [7:0]  overrun_count
);
  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, OUT} state_t;
  state_t state_q, state_d;
  logic phase_q, phase_d;
  logic [2:0][15:0] wave_q;
  logic [2:0] mute_q;
  logic [2:0][7:0] gsnap_q, gain_q, gain_d;
  logic [23:0] prod_q, prod_d, mul_p;
  logic signed [25:0] acc_q, acc_d, sh;
  logic [15:0] out_q, out_d, sat, mul_a;
  logic [7:0] ovr_q, ovr_d, mul_g;
  logic out_ready_q, out_ready_d, mul_m, cap;
  assign cap = state_q == IDLE && in_ready;
  // Product is registered and accumulated a cycle later; OUT spends one cycle draining it
  always_comb begin
    mul_a = state_q == MAC1 ? wave_q[1] : state_q == MAC2 ? wave_q[2] : wave_q[0];
    mul_g = state_q == MAC1 ? gsnap_q[1] : state_q == MAC2 ? gsnap_q[2] : gsnap_q[0];
    mul_m = state_q == MAC1 ? mute_q[1] : state_q == MAC2 ? mute_q[2] : mute_q[0];
    mul_p = $signed(mul_a) * $signed({1'b0, mul_g});
    prod_d = (state_q == MAC0 || state_q == MAC1 || state_q == MAC2) && !mul_m ? mul_p : '0;
    acc_d = cap ? '0 : state_q == IDLE ? acc_q : acc_q + 26'($signed(prod_q));
    sh = acc_q >>> 7;
    sat = sh[25:15] != {11{sh[25]}} ? (sh[25] ? 16'h8000 : 16'h7fff) : sh[15:0];
    out_ready_d = state_q == OUT && phase_q;
    out_d = out_ready_d ? sat : out_q;
    phase_d = state_q == OUT && !phase_q;
    ovr_d = in_ready && state_q != IDLE ? (SAT_OVR && &ovr_q ? ovr_q : ovr_q + 8'd1) : ovr_q;
    for (int i = 0; i < 3; i++) gain_d[i] = gain_wr && gain_sel == 2'(i) ? gain_data : gain_q[i];
    case (state_q)
      IDLE:    state_d = in_ready ? MAC0 : IDLE;
      MAC0:    state_d = MAC1;
      MAC1:    state_d = MAC2;
      MAC2:    state_d = OUT;
      OUT:     state_d = phase_q ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      acc_q <= '0;
      prod_q <= '0;
      out_q <= '0;
      out_ready_q <= 1'b0;
      ovr_q <= '0;
      gain_q <= {3{DEFAULT_GAIN}};
      gsnap_q <= {3{DEFAULT_GAIN}};
      wave_q <= '0;
      mute_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      acc_q <= acc_d;
      prod_q <= prod_d;
      out_q <= out_d;
      out_ready_q <= out_ready_d;
      ovr_q <= ovr_d;
      gain_q <= gain_d;
      if (cap) begin
        wave_q <= {wave2_in, wave1_in, wave0_in};
        mute_q <= mute;
        gsnap_q <= gain_q;
      end
    end
  end
  assign out = out_q;
  assign out_ready = out_ready_q;
  assign busy = state_q != IDLE;
  assign overrun_count = ovr_q;
endmodule

// File: tb/tb_voice_mix_sequencer.sv
// tb_voice_mix_sequencer: table-driven mix vectors plus directed overrun, gain-timing and reset sequences
module tb_voice_mix_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, in_ready, gain_wr, out_ready, busy;
  logic [15:0] wave0, wave1, wave2, out;
  logic [2:0] mute;
  logic [1:0] gain_sel;
  logic [7:0] gain_data, ovr;
  int tests = 0, fails = 0;

  voice_mix_sequencer dut (
    .clk(clk), .reset(reset), .in_ready(in_ready),
    .wave0_in(wave0), .wave1_in(wave1), .wave2_in(wave2),
    .mute(mute), .gain_wr(gain_wr), .gain_sel(gain_sel), .gain_data(gain_data),
    .out(out), .out_ready(out_ready), .busy(busy), .overrun_count(ovr)
  );

  typedef struct {
    int w0, w1, w2;
    logic [2:0] m;
    logic [7:0] g0, g1, g2;
    int exp;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_gain(input logic [1:0] sel, input logic [7:0] data);
    gain_wr = 1'b1; gain_sel = sel; gain_data = data;
    tick;
    gain_wr = 1'b0;
  endtask

  task automatic start(input int w0, input int w1, input int w2, input logic [2:0] m);
    wave0 = 16'(w0); wave1 = 16'(w1); wave2 = 16'(w2); mute = m;
    in_ready = 1'b1;
    tick;
    in_ready = 1'b0;
  endtask

  task automatic wait_out(output int res, output int lat, output int bc);
    lat = -1; res = 0; bc = 0;
    for (int j = 1; j <= 20; j++) begin
      bc += int'(busy);
      tick;
      if (out_ready) begin
        lat = j;
        res = int'($signed(out));
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  initial begin
    int res, lat, bc, pulses;
    vecs[0] = '{1000, 2000, -500, 3'b000, 128, 128, 128, 2500};
    vecs[1] = '{30000, 30000, 0, 3'b000, 128, 128, 128, 32767};
    vecs[2] = '{-30000, -30000, -30000, 3'b000, 128, 128, 128, -32768};
    vecs[3] = '{1001, 5, 5, 3'b000, 64, 0, 0, 500};
    vecs[4] = '{-1001, 5, 5, 3'b000, 64, 0, 0, -501};
    vecs[5] = '{100, 200, 300, 3'b010, 128, 128, 128, 400};
    vecs[6] = '{1000, 1000, 1000, 3'b111, 128, 128, 128, 0};
    vecs[7] = '{256, 0, 0, 3'b000, 255, 128, 0, 510};
    reset = 1'b1; in_ready = 1'b0; gain_wr = 1'b0; gain_sel = '0; gain_data = '0;
    wave0 = '0; wave1 = '0; wave2 = '0; mute = '0;
    tick; tick;
    reset = 1'b0;
    chk("reset_out", int'(out), 0);
    chk("reset_out_ready", int'(out_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(ovr), 0);

    for (int i = 0; i < 8; i++) begin
      set_gain(2'd0, vecs[i].g0);
      set_gain(2'd1, vecs[i].g1);
      set_gain(2'd2, vecs[i].g2);
      start(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].m);
      wait_out(res, lat, bc);
      chk($sformatf("vec%0d_out", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 5);
      tick;
      chk($sformatf("vec%0d_pulse_width", i), int'(out_ready), 0);
      chk($sformatf("vec%0d_hold", i), int'($signed(out)), vecs[i].exp);
    end

    // reset in MAC1 aborts the sample and restores default gains
    start(1000, 1000, 1000, 3'b000);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_out", int'(out), 0);
    chk("abort_busy", int'(busy), 0);
    pulses = int'(out_ready);
    for (int j = 0; j < 8; j++) begin tick; pulses += int'(out_ready); end
    chk("abort_no_pulse", pulses, 0);
    start(7, 7, 7, 3'b000);
    wait_out(res, lat, bc);
    chk("after_abort_out", res, 21);

    // overrun: second pulse two cycles after the first is dropped
    tick;
    start(1000, 2000, -500, 3'b000);
    tick;
    in_ready = 1'b1;
    tick;
    in_ready = 1'b0;
    pulses = 0;
    for (int j = 0; j < 12; j++) begin tick; pulses += int'(out_ready); end
    chk("overrun_one_pulse", pulses, 1);
    chk("overrun_count1", int'(ovr), 1);
    chk("overrun_out", int'($signed(out)), 2500);
    in_ready = 1'b1;
    repeat (400) tick;
    in_ready = 1'b0;
    repeat (10) tick;
    chk("overrun_saturated", int'(ovr), 255);

    // gain write during MAC0 affects only the following sample
    reset = 1'b1; tick; reset = 1'b0;
    start(100, 100, 100, 3'b000);
    gain_wr = 1'b1; gain_sel = 2'd1; gain_data = 8'd0;
    tick;
    gain_wr = 1'b0;
    wait_out(res, lat, bc);
    chk("gain_snapshot_out", res, 300);
    tick;
    start(100, 100, 100, 3'b000);
    wait_out(res, lat, bc);
    chk("gain_applied_out", res, 200);
    tick;
    start(100, 100, 100, 3'b100);
    wait_out(res, lat, bc);
    chk("mute2_out", res, 100);

    // gain_sel=3 changes nothing
    reset = 1'b1; tick; reset = 1'b0;
    set_gain(2'd3, 8'd0);
    start(100, 100, 100, 3'b000);
    wait_out(res, lat, bc);
    chk("sel3_ignored_out", res, 300);

    // gain write coinciding with capture snapshots the old value
    tick;
    gain_wr = 1'b1; gain_sel = 2'd0; gain_data = 8'd0;
    start(100, 100, 100, 3'b000);
    gain_wr = 1'b0;
    wait_out(res, lat, bc);
    chk("same_cycle_snapshot_out", res, 300);
    tick;
    start(100, 100, 100, 3'b000);
    wait_out(res, lat, bc);
    chk("same_cycle_written_out", res, 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
